// File: rtl/inst_mem_loader.sv
// Instruction memory with a valid/ready program loader and a registered,
// one-cycle-latency fetch port that flags fetches outside the loaded program.
module inst_mem_loader #(
  parameter int                DATA_W   = 13,
  parameter int                ADDR_W   = 4,
  parameter int                DEPTH    = 16,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic [ADDR_W:0]   prog_len,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_inst,
  output logic              fetch_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

  state_t            state, nextState;
  logic [ADDR_W:0]   wrPtr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic accept, complete, startLoad, fetchHit;

  always_comb begin
    nextState  = state;
    load_ready = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    complete   = 1'b0;
    startLoad  = 1'b0;
    fetchHit   = 1'b0;

    unique case (state)
      IDLE: begin
        if (load_start) begin
          startLoad = 1'b1;
          nextState = LOAD;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        busy       = 1'b1;
        accept     = load_valid;
        // Writing the top slot ends the load even without load_last, so
        // the pointer never wraps back onto word 0.
        complete   = load_valid & (load_last | (wrPtr == LAST_PTR));
        if (complete) nextState = RUN;
      end
      RUN: begin
        fetchHit = ({1'b0, fetch_addr} < prog_len);
        if (load_start) begin
          startLoad = 1'b1;
          nextState = LOAD;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      wrPtr     <= '0;
      prog_len  <= '0;
      load_done <= 1'b0;
    end else begin
      state     <= nextState;
      load_done <= complete;
      if (startLoad) begin
        wrPtr    <= '0;
        prog_len <= '0;
      end else if (accept) begin
        wrPtr <= wrPtr + 1'b1;
        if (complete) prog_len <= wrPtr + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) mem[wrPtr[ADDR_W-1:0]] <= load_data;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_inst  <= NOP_WORD;
    end else begin
      fetch_valid <= fetch_req;
      if (fetch_req) begin
        fetch_err  <= ~fetchHit;
        fetch_inst <= fetchHit ? mem[fetch_addr] : NOP_WORD;
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed plus randomized bench for inst_mem_loader against a queue/array
// model of the loaded program and a pipelined view of the fetch result.
module tb_inst_mem_loader;

  localparam int DW    = 13;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam logic [DW-1:0] NOP = '0;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          load_start, load_valid, load_last;
  logic [DW-1:0] load_data;
  logic          load_ready, load_done;
  logic [AW:0]   prog_len;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_valid, fetch_err, busy;
  logic [DW-1:0] fetch_inst;

  inst_mem_loader #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .DEPTH   (DEPTH),
    .NOP_WORD(NOP)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_done  (load_done),
    .prog_len   (prog_len),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_valid(fetch_valid),
    .fetch_inst (fetch_inst),
    .fetch_err  (fetch_err),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: program contents, length, and whether a load is open
  // or a program is runnable.
  logic [DW-1:0] mMem [DEPTH];
  int            mPtr, mLen;
  bit            loading, running;
  logic [DW-1:0] lastInst;
  bit            lastErr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic resetDut();
    nRST       = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = '0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    #2;
    loading  = 0;
    running  = 0;
    mPtr     = 0;
    mLen     = 0;
    lastInst = NOP;
    lastErr  = 0;
    chk("rst_load_ready", 32'(load_ready), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_prog_len", 32'(prog_len), 32'd0);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
    chk("rst_fetch_inst", 32'(fetch_inst), 32'(NOP));
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // One clock of stimulus; expectations come from the model as it stands
  // before the edge, then the model advances.
  task automatic cycle(input bit start, input bit v, input logic [DW-1:0] d,
                       input bit last, input bit freq, input logic [AW-1:0] faddr);
    bit hit;
    bit expDone;
    load_start = start;
    load_valid = v;
    load_data  = d;
    load_last  = last;
    fetch_req  = freq;
    fetch_addr = faddr;
    #1;
    chk("pre_load_ready", 32'(load_ready), 32'(loading));

    if (freq) begin
      hit      = running && (int'(faddr) < mLen);
      lastInst = hit ? mMem[faddr] : NOP;
      lastErr  = !hit;
    end

    expDone = 0;
    if (loading && v) begin
      mMem[mPtr] = d;
      mPtr++;
      if (last || mPtr == DEPTH) begin
        loading = 0;
        running = 1;
        mLen    = mPtr;
        expDone = 1;
      end
    end else if (start && !loading) begin
      loading = 1;
      running = 0;
      mPtr    = 0;
      mLen    = 0;
    end

    @(posedge CLK);
    #1;
    chk("load_done", 32'(load_done), 32'(expDone));
    chk("prog_len", 32'(prog_len), 32'(mLen));
    chk("busy", 32'(busy), 32'(loading));
    chk("load_ready", 32'(load_ready), 32'(loading));
    chk("fetch_valid", 32'(fetch_valid), 32'(freq));
    chk("fetch_inst", 32'(fetch_inst), 32'(lastInst));
    chk("fetch_err", 32'(fetch_err), 32'(lastErr));
  endtask

  task automatic idle();
    cycle(0, 0, '0, 0, 0, '0);
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    cycle(0, 0, '0, 0, 1, a);
  endtask

  logic [DW-1:0] prog3 [3];
  int            n, lastAt, i;
  bit            v;

  initial begin
    prog3[0] = 13'h109B;
    prog3[1] = 13'h0424;
    prog3[2] = 13'h1C0C;

    resetDut();
    fetch(0);
    idle();

    // Three-word program, then back-to-back fetches inside and outside it.
    cycle(1, 0, '0, 0, 0, '0);
    for (int k = 0; k < 3; k++) cycle(0, 1, prog3[k], k == 2, 0, '0);
    fetch(0);
    fetch(1);
    fetch(2);
    fetch(3);
    fetch(15);
    idle();

    // Twenty words with no load_last: stops at the top slot.
    cycle(1, 0, '0, 0, 0, '0);
    for (int k = 0; k < 20; k++) cycle(0, 1, DW'($urandom), 0, 0, '0);
    fetch(15);
    fetch(0);
    idle();

    // Stalled handshake.
    cycle(1, 0, '0, 0, 0, '0);
    cycle(0, 1, 13'h0AAA, 0, 0, '0);
    cycle(0, 0, 13'h1555, 0, 0, '0);
    cycle(0, 1, 13'h0F0F, 0, 0, '0);
    cycle(0, 0, 13'h1111, 1, 0, '0);
    cycle(0, 1, 13'h1234, 1, 1, 4'd0);
    for (int k = 0; k < 4; k++) fetch(AW'(k));
    idle();

    // Randomized programs with stalls and fetches during and after loading.
    repeat (8) begin
      n      = $urandom_range(1, 20);
      lastAt = ($urandom_range(0, 1) != 0) ? $urandom_range(0, n - 1) : -1;
      cycle(1, 0, '0, 0, ($urandom_range(0, 1) != 0), AW'($urandom));
      i = 0;
      while (i < n) begin
        v = ($urandom_range(0, 9) < 7);
        cycle(0, v, DW'($urandom), (i == lastAt), ($urandom_range(0, 1) != 0), AW'($urandom));
        if (v) i++;
      end
      repeat (12) cycle(0, 0, '0, 0, ($urandom_range(0, 3) != 0), AW'($urandom));
    end

    // Reload while fetching, then reset partway through the reload.
    cycle(1, 0, '0, 0, 0, '0);
    for (int k = 0; k < 3; k++) cycle(0, 1, prog3[k], k == 2, 0, '0);
    cycle(1, 0, '0, 0, 1, 4'd1);
    cycle(0, 1, 13'h0101, 0, 0, '0);
    cycle(0, 1, 13'h0202, 0, 0, '0);
    resetDut();
    fetch(0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
